// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter using reverse double-dabble.
// One shift/correct iteration per clock under a start/done handshake.
// An input with any digit above 9 is rejected in one clock with err set.
module bcd2bin_seq #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   binAcc_q;
  logic [BIN_W-1:0]   binAcc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               errFlag_q;
  logic [BIN_W-1:0]   binOut_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               invalidDigit;

  // Flag the incoming word if any of its digits is not a legal BCD digit.
  always_comb begin
    invalidDigit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        invalidDigit = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift the whole working register right,
  // then pull every digit that landed at 8 or above back down by 3.
  always_comb begin
    bcd_d    = bcd_q >> 1;
    binAcc_d = {bcd_q[0], binAcc_q[BIN_W-1:1]};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_d[4*i + 3]) begin
        bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with registered handshake outputs; start is ignored unless idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      binAcc_q  <= '0;
      cnt_q     <= '0;
      errFlag_q <= 1'b0;
      binOut_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bcd_q     <= bcd_in;
            binAcc_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            errFlag_q <= invalidDigit;
            state_q   <= invalidDigit ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          bcd_q    <= bcd_d;
          binAcc_q <= binAcc_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          if (errFlag_q) begin
            binOut_q <= '0;
            err_q    <= 1'b1;
          end else begin
            binOut_q <= binAcc_q;
            err_q    <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bin_out = binOut_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed and random checks of bcd2bin_seq with a scoreboard
// of expected results (value, error flag, latency) drained by a done monitor.
module tb_bcd2bin_seq;

  localparam int N_DIGITS = 4;
  localparam int BIN_W    = 14;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               cyc;
    int               lat;
  } sbEntry_t;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  sbEntry_t sb[$];
  int       nChecks;
  int       nFail;
  int       cycleCnt;
  int       doneCnt;

  bcd2bin_seq #(
    .N_DIGITS(N_DIGITS),
    .BIN_W   (BIN_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .bin_out(bin_out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge count used to time each conversion.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Hard stop in case the sequence wedges.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts, asserts, reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent decimal model of a BCD word.
  function automatic sbEntry_t refModel(input logic [15:0] v);
    sbEntry_t e;
    int       acc;
    bit       bad;
    logic [3:0] d;
    acc = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) bad = 1;
      acc = acc * 10 + int'(d);
    end
    e.bin = bad ? '0 : BIN_W'(acc);
    e.err = bad;
    e.lat = bad ? 1 : BIN_W + 1;
    e.cyc = 0;
    return e;
  endfunction

  // Pulse start for one edge; queue the expected result if it should be accepted.
  task automatic applyStimulus(input logic [15:0] v, input bit expectAccept);
    sbEntry_t e;
    @(posedge clk); #2;
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk); #1;
    if (expectAccept) begin
      e = refModel(v);
      e.cyc = cycleCnt;
      sb.push_back(e);
    end
    #1;
    start = 1'b0;
  endtask

  // Wait, bounded, for the scoreboard to empty.
  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #2;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  // Compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    sbEntry_t e;
    if (!rst && done) begin
      doneCnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("bin_out", 32'(bin_out), 32'(e.bin));
        checkOutput("err", 32'(err), 32'(e.err));
        checkOutput("latency", 32'(cycleCnt - e.cyc), 32'(e.lat));
      end
    end
  end

  initial begin
    int busyCycles;
    int doneBase;
    logic [15:0] v;

    nChecks  = 0;
    nFail    = 0;
    cycleCnt = 0;
    doneCnt  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bcd_in   = '0;
    #12;
    checkOutput("reset_bin", 32'(bin_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    rst = 1'b0;

    $display("[TB] zero input and busy window");
    applyStimulus(16'h0000, 1'b1);
    busyCycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busyCycles++;
      @(posedge clk); #2;
    end
    checkOutput("busy_cycles", 32'(busyCycles), 32'd15);
    waitDrain(5);

    $display("[TB] full-scale and mixed values");
    applyStimulus(16'h9999, 1'b1);
    waitDrain(30);
    applyStimulus(16'h1023, 1'b1);
    waitDrain(30);

    $display("[TB] invalid digit then recovery");
    applyStimulus(16'h12A4, 1'b1);
    waitDrain(5);
    applyStimulus(16'h0042, 1'b1);
    waitDrain(30);

    $display("[TB] start while busy is ignored");
    doneBase = doneCnt;
    applyStimulus(16'h0500, 1'b1);
    @(posedge clk); #2;
    applyStimulus(16'h0777, 1'b0);
    repeat (5) begin @(posedge clk); #2; end
    applyStimulus(16'h0777, 1'b0);
    waitDrain(30);
    repeat (20) begin @(posedge clk); #2; end
    checkOutput("single_done", 32'(doneCnt - doneBase), 32'd1);

    $display("[TB] reset aborts a conversion");
    doneBase = doneCnt;
    applyStimulus(16'h4321, 1'b1);
    repeat (5) begin @(posedge clk); #2; end
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("abort_bin", 32'(bin_out), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #2; end
    checkOutput("abort_no_done", 32'(doneCnt - doneBase), 32'd0);
    applyStimulus(16'h0008, 1'b1);
    waitDrain(30);

    $display("[TB] start held high, random valid values");
    @(posedge clk); #2;
    start = 1'b1;
    for (int i = 0; i < 48; i++) begin
      sbEntry_t e;
      if (i == 0) v = 16'h9999;
      else if (i == 1) v = 16'h0000;
      else begin
        for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      bcd_in = v;
      if (i == 0) begin
        @(posedge clk);
      end else begin
        repeat (BIN_W + 2) @(posedge clk);
      end
      #1;
      e = refModel(v);
      e.cyc = cycleCnt;
      sb.push_back(e);
      if (i == 47) start = 1'b0;
    end
    waitDrain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the switch-to-display binary-to-BCD path.
- Takes N_DIGITS packed BCD digits and produces the unsigned binary value.
- Uses reverse double-dabble: one shift/correct iteration per clock, under a start/done handshake.
- Sits between a digit-entry source (switch or keypad capture) and downstream arithmetic.

Parameters:
- N_DIGITS, 4, number of BCD digits on the input.
- BIN_W, 14, width of the binary result; must satisfy 2^BIN_W > 10^N_DIGITS − 1 (14 covers 9999).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled on the rising edge.
- bcd_in  input  4*N_DIGITS  packed BCD; digit 0 (units) in [3:0].
- bin_out  output  BIN_W  binary result; held stable until the next accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/err are updated.
- err  output  1  set with done when any input digit is greater than 9.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; bin_out=0, busy=0, done=0, err=0; working register and iteration counter cleared.
- Reset mid-conversion aborts immediately. No done is issued for the aborted request.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 on edge k: capture bcd_in into the working register.
  - The working register is {bcd_reg[4*N_DIGITS-1:0], bin_reg[BIN_W-1:0]}; bin_reg is cleared.
  - Counter is cleared; busy=1 after edge k.
- Digit check at edge k: if any digit of bcd_in is greater than 9, go to FINISH with the error flag latched. No SHIFT cycles run.
- SHIFT, one iteration per edge:
  - Logically shift the full working register right by 1; the bcd_reg LSB moves into the bin_reg MSB.
  - Then, for every 4-bit digit in the shifted bcd_reg, if digit ≥ 8, subtract 3 from it. All digits are corrected in parallel within the same cycle.
  - The counter increments. After BIN_W iterations (edges k+1..k+BIN_W), go to FINISH.
- FINISH, one edge (k+BIN_W+1 normal; k+1 on error):
  - Normal: bin_out←bin_reg, err←0.
  - Error: bin_out←0, err←1.
  - done=1 for exactly one cycle, busy→0, return to IDLE.
- Latency:
  - Normal: done high in the cycle after edge k+BIN_W+1, i.e. 15 clocks after the start edge for defaults.
  - Error: done after 1 clock.
- start while busy=1 is ignored; it is not queued.
- start high in the same cycle done is high is accepted, since the state is IDLE at that edge. Back-to-back conversions are allowed with no dead cycle beyond FINISH.
- bcd_in is only sampled at the accepted start edge; changes during SHIFT have no effect.
- bin_out and err hold their values between done pulses.
- Holding start high continuously re-triggers a new conversion every BIN_W+2 clocks.
- Width rule: a fully-valid 10^N_DIGITS−1 input must fit in BIN_W. After BIN_W iterations, bcd_reg is zero for every valid input.

Test Plan:
- Reset then bcd_in=16'h0000, start pulse → done after 15 clocks, bin_out=0, err=0, busy high for exactly those cycles.
- bcd_in=16'h9999 → bin_out=14'd9999 (0x270F), err=0. bcd_in=16'h1023 → bin_out=1023.
- bcd_in=16'h12A4 (invalid digit) → done 1 clock after start, err=1, bin_out=0. A following valid 16'h0042 → err=0, bin_out=42.
- Start 16'h0500, then pulse start with 16'h0777 at clocks 3 and 10 → only one done, bin_out=500.
- Assert rst at clock 7 of a 16'h4321 conversion → all outputs 0 immediately, no done. A new start with 16'h0008 → bin_out=8.
- Start held high with bcd_in sweeping 0000..9999 in random order, checked against a reference model → every done carries the correct value, period BIN_W+2 clocks.
